cache_data_array: RTL and testbench

- Parametrised multi-line cache data store. Holds NUM_LINES lines of LINE_BYTES bytes each.
- CPU side: word-granular reads and byte-enabled word writes.
- Memory side: multi-beat line refill port with valid/ready handshake and a fill FSM.
- Sits between the cache controller (tag/valid logic) and the memory refill path.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_line_reg.sv | 26 ++
 rtl/cache_data_array.sv | 185 ++++++++++++++++++
 tb/tb_cache_data_array.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared fill FSM states, width helper and default geometry for the cache data array
package cache_pkg;

    localparam int DEF_NUM_LINES  = 8;
    localparam int DEF_LINE_BYTES = 32;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillStateT;

    // Never returns zero so that degenerate geometries still get a one-bit field.
    function automatic int minWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W  = minWidth(DEF_NUM_LINES);
    localparam int DEF_WOFF_W = minWidth(DEF_LINE_BYTES / DEF_WORD_BYTES);
    localparam int DEF_BEATS  = DEF_LINE_BYTES / DEF_BEAT_BYTES;
    localparam int DEF_BEAT_W = minWidth(DEF_BEATS);

endpackage

// File: rtl/cache_line_reg.sv
// rtl/cache_line_reg.sv - one cache line of byte registers with per-byte write enables
module cache_line_reg
    import cache_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LINE_BYTES-1:0]   byteWe,
    input  logic [8*LINE_BYTES-1:0] wrData,
    output logic [8*LINE_BYTES-1:0] lineData
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lineData <= '0;
        end else begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (byteWe[b]) begin
                    lineData[8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - cache data store with CPU word port and multi-beat refill FSM; optional CACHE_DATA_PARITY_EN
module cache_data_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int BEAT_BYTES = DEF_BEAT_BYTES,
    localparam int IDX_W     = minWidth(NUM_LINES),
    localparam int WOFF_W    = minWidth(LINE_BYTES / WORD_BYTES),
    localparam int BEATS     = LINE_BYTES / BEAT_BYTES,
    localparam int BEAT_W    = minWidth(BEATS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WOFF_W-1:0]       word_off,
    input  logic [WORD_BYTES-1:0]   wr_be,
    input  logic [8*WORD_BYTES-1:0] wr_data,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    fill_start,
    input  logic [IDX_W-1:0]        fill_idx,
    input  logic                    fill_valid,
    input  logic [8*BEAT_BYTES-1:0] fill_data,
    output logic                    fill_ready,
    output logic                    fill_done,
    output logic                    busy,
    output logic                    par_err
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORDS  = LINE_BYTES / WORD_BYTES;

    fillStateT          state, stateNext;
    logic [BEAT_W-1:0]  beatCnt, beatCntNext;
    logic [IDX_W-1:0]   fillIdxQ, fillIdxNext;

    logic               cpuRd, cpuWr, fillWr;
    logic [LINE_BYTES-1:0] cpuMask, fillMask;
    logic [LINE_W-1:0]  lineWrData;
    logic [LINE_BYTES-1:0] lineWe [NUM_LINES];
    logic [LINE_W-1:0]  lineData [NUM_LINES];
    logic [WORD_W-1:0]  rdWord;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beatCnt  <= '0;
            fillIdxQ <= '0;
        end else begin
            state    <= stateNext;
            beatCnt  <= beatCntNext;
            fillIdxQ <= fillIdxNext;
        end
    end

    always_comb begin
        stateNext   = state;
        beatCntNext = beatCnt;
        fillIdxNext = fillIdxQ;
        fill_ready  = 1'b0;
        fill_done   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    stateNext   = FILL;
                    fillIdxNext = fill_idx;
                    beatCntNext = '0;
                end
            end
            FILL: begin
                fill_ready = 1'b1;
                busy       = 1'b1;
                if (fill_valid) begin
                    if (beatCnt == BEAT_W'(BEATS - 1)) begin
                        stateNext   = DONE;
                        beatCntNext = '0;
                    end else begin
                        beatCntNext = beatCnt + 1'b1;
                    end
                end
            end
            DONE: begin
                fill_done = 1'b1;
                busy      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // CPU accesses and refill beats never overlap: CPU only in IDLE, beats only in FILL.
    assign cpuRd  = (state == IDLE) && rd_en;
    assign cpuWr  = (state == IDLE) && wr_en;
    assign fillWr = (state == FILL) && fill_valid;

    always_comb begin
        cpuMask    = LINE_BYTES'(wr_be) << (word_off * WORD_BYTES);
        fillMask   = LINE_BYTES'({BEAT_BYTES{1'b1}}) << (beatCnt * BEAT_BYTES);
        lineWrData = cpuWr ? {WORDS{wr_data}} : {BEATS{fill_data}};
        for (int l = 0; l < NUM_LINES; l++) begin
            lineWe[l] = '0;
            if (cpuWr && (idx == IDX_W'(l))) begin
                lineWe[l] = cpuMask;
            end else if (fillWr && (fillIdxQ == IDX_W'(l))) begin
                lineWe[l] = fillMask;
            end
        end
    end

    for (genvar l = 0; l < NUM_LINES; l++) begin : genLines
        cache_line_reg #(
            .LINE_BYTES(LINE_BYTES)
        ) uLine (
            .clk     (clk),
            .reset   (reset),
            .byteWe  (lineWe[l]),
            .wrData  (lineWrData),
            .lineData(lineData[l])
        );
    end

    assign rdWord = WORD_W'(lineData[idx] >> (word_off * WORD_W));

    // Read samples storage before a same-cycle write lands, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= cpuRd;
            if (cpuRd) begin
                rd_data <= rdWord;
            end
        end
    end

`ifdef CACHE_DATA_PARITY_EN
    logic [LINE_BYTES-1:0] parMem [NUM_LINES];
    logic [WORD_BYTES-1:0] rdPar;
    logic                  rdParBad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                parMem[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LINES; l++) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (lineWe[l][b]) begin
                        parMem[l][b] <= ^lineWrData[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdPar    = WORD_BYTES'(parMem[idx] >> (word_off * WORD_BYTES));
        rdParBad = 1'b0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (rdPar[i] != ^rdWord[8*i +: 8]) begin
                rdParBad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_err <= 1'b0;
        end else begin
            par_err <= cpuRd && rdParBad;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_data_array.sv
// tb/tb_cache_data_array.sv - directed self-checking bench for cache_data_array
module tb_cache_data_array;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  idx = '0;
    logic [2:0]  word_off = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        fill_start = 1'b0;
    logic [2:0]  fill_idx = '0;
    logic        fill_valid = 1'b0;
    logic [63:0] fill_data = '0;
    logic        fill_ready;
    logic        fill_done;
    logic        busy;
    logic        par_err;

    int checks = 0;
    int failures = 0;

    cache_data_array dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .idx       (idx),
        .word_off  (word_off),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .fill_start(fill_start),
        .fill_idx  (fill_idx),
        .fill_valid(fill_valid),
        .fill_data (fill_data),
        .fill_ready(fill_ready),
        .fill_done (fill_done),
        .busy      (busy),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuRead(input logic [2:0] i, input logic [2:0] o, input logic [31:0] exp, input string tag);
        rd_en = 1'b1;
        idx = i;
        word_off = o;
        tick();
        rd_en = 1'b0;
        checkVal({tag, "_valid"}, 64'(rd_valid), 64'd1);
        checkVal(tag, 64'(rd_data), 64'(exp));
        checkVal({tag, "_par"}, 64'(par_err), 64'd0);
    endtask

    task automatic cpuWrite(input logic [2:0] i, input logic [2:0] o, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1;
        idx = i;
        word_off = o;
        wr_be = be;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [63:0] beats [4];
        beats[0] = 64'h0706050403020100;
        beats[1] = 64'h0F0E0D0C0B0A0908;
        beats[2] = 64'h1716151413121110;
        beats[3] = 64'h1F1E1D1C1B1A1918;

        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_ready", 64'(fill_ready), 64'd0);
        checkVal("rst_done", 64'(fill_done), 64'd0);
        checkVal("rst_rvalid", 64'(rd_valid), 64'd0);
        checkVal("rst_rdata", 64'(rd_data), 64'd0);
        reset = 1'b1;
        tick();

        cpuRead(3'd3, 3'd2, 32'h0, "rd_reset_word");
        checkVal("idle_busy", 64'(busy), 64'd0);

        cpuWrite(3'd1, 3'd0, 4'hF, 32'h11223344);
        cpuWrite(3'd1, 3'd0, 4'b0101, 32'hAABBCCDD);
        cpuRead(3'd1, 3'd0, 32'h11BB33DD, "rd_byte_merge");
        tick();
        checkVal("hold_rvalid", 64'(rd_valid), 64'd0);
        checkVal("hold_rdata", 64'(rd_data), 64'h11BB33DD);

        cpuWrite(3'd1, 3'd0, 4'h0, 32'hFFFFFFFF);
        cpuRead(3'd1, 3'd0, 32'h11BB33DD, "rd_be_zero");

        cpuWrite(3'd2, 3'd1, 4'hF, 32'hCAFEBABE);
        rd_en = 1'b1;
        wr_en = 1'b1;
        idx = 3'd2;
        word_off = 3'd1;
        wr_be = 4'hF;
        wr_data = 32'h12345678;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        checkVal("rw_old_data", 64'(rd_data), 64'hCAFEBABE);
        cpuRead(3'd2, 3'd1, 32'h12345678, "rw_new_data");

        fill_start = 1'b1;
        fill_idx = 3'd5;
        tick();
        fill_start = 1'b0;
        checkVal("fill_ready", 64'(fill_ready), 64'd1);
        checkVal("fill_busy", 64'(busy), 64'd1);
        fill_valid = 1'b1;
        fill_data = beats[0];
        tick();
        fill_valid = 1'b0;
        rd_en = 1'b1;
        wr_en = 1'b1;
        idx = 3'd2;
        word_off = 3'd1;
        wr_be = 4'hF;
        wr_data = 32'h0;
        fill_start = 1'b1;
        fill_idx = 3'd2;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        fill_start = 1'b0;
        checkVal("busy_rvalid", 64'(rd_valid), 64'd0);
        checkVal("busy_rdata", 64'(rd_data), 64'h12345678);
        for (int b = 1; b < 4; b++) begin
            fill_valid = 1'b1;
            fill_data = beats[b];
            tick();
            fill_valid = 1'b0;
            if (b < 3) begin
                tick();
                checkVal("stall_ready", 64'(fill_ready), 64'd1);
            end
        end
        checkVal("done_pulse", 64'(fill_done), 64'd1);
        checkVal("done_ready", 64'(fill_ready), 64'd0);
        checkVal("done_busy", 64'(busy), 64'd1);
        fill_start = 1'b1;
        fill_idx = 3'd3;
        tick();
        fill_start = 1'b0;
        checkVal("done_end", 64'(fill_done), 64'd0);
        checkVal("done_start_ign", 64'(busy), 64'd0);

        cpuRead(3'd5, 3'd7, 32'h1F1E1D1C, "fill_w7");
        cpuRead(3'd5, 3'd0, 32'h03020100, "fill_w0");
        cpuRead(3'd5, 3'd3, 32'h0F0E0D0C, "fill_w3");
        cpuRead(3'd2, 3'd1, 32'h12345678, "busy_no_write");

        fill_start = 1'b1;
        fill_idx = 3'd6;
        rd_en = 1'b1;
        idx = 3'd5;
        word_off = 3'd0;
        tick();
        fill_start = 1'b0;
        rd_en = 1'b0;
        checkVal("start_rd_valid", 64'(rd_valid), 64'd1);
        checkVal("start_rd_data", 64'(rd_data), 64'h03020100);
        checkVal("start_busy", 64'(busy), 64'd1);
        fill_valid = 1'b1;
        fill_data = beats[0];
        tick();
        fill_data = beats[1];
        tick();
        fill_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkVal("arst_busy", 64'(busy), 64'd0);
        checkVal("arst_ready", 64'(fill_ready), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        cpuRead(3'd6, 3'd0, 32'h0, "arst_line6_w0");
        cpuRead(3'd6, 3'd2, 32'h0, "arst_line6_w2");
        cpuRead(3'd5, 3'd7, 32'h0, "arst_line5_w7");

`ifdef CACHE_DATA_PARITY_EN
        cpuWrite(3'd0, 3'd0, 4'hF, 32'h44332211);
        force dut.genLines[0].uLine.lineData = {224'h0, 32'h44322211};
        rd_en = 1'b1;
        idx = 3'd0;
        word_off = 3'd0;
        tick();
        rd_en = 1'b0;
        checkVal("par_bad_data", 64'(rd_data), 64'h44322211);
        checkVal("par_bad_flag", 64'(par_err), 64'd1);
        cpuRead(3'd0, 3'd1, 32'h0, "par_good_word");
        release dut.genLines[0].uLine.lineData;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
